// File: rtl/lsu_rmw.sv
// Load/store initiator: word-aligned memory accesses, read-modify-write for SB/SH, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned H/W requests with rsp_err.
module lsu_rmw #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | word read; buffer captured on exit
  // WR    | word write (SW direct, SB/SH merged)
  // RESP  | one-cycle response pulse
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic        legal, misaligned, req_err;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic [31:0] op_wdata;
  logic [31:0] buf_word;
  logic [31:0] merged;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign accept = req_valid && req_ready;

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    if (req_we)
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
`endif
    req_err = !legal || misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // strobes depend on the state register only; inputs affect just the next state
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                       state_nx = RESP;
          else if (!req_we)                  state_nx = RD;
          else if (req_funct3[1:0] == 2'b10) state_nx = WR;
          else                               state_nx = RD;
        end
      end
      RD: begin
        mem_read = 1'b1;
        state_nx = op_we ? WR : RESP;
      end
      WR: begin
        mem_write = 1'b1;
        state_nx  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (op_lane)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_f3[1:0])
      2'b00:   ld_val = {{24{ld_byte[7] & ~op_f3[2]}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~op_f3[2]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = buf_word;
    case (op_f3[1:0])
      2'b00: begin
        case (op_lane)
          2'd0: merged[7:0]   = op_wdata[7:0];
          2'd1: merged[15:8]  = op_wdata[7:0];
          2'd2: merged[23:16] = op_wdata[7:0];
          2'd3: merged[31:24] = op_wdata[7:0];
          default: merged = buf_word;
        endcase
      end
      2'b01: begin
        if (op_lane[1]) merged[31:16] = op_wdata[15:0];
        else            merged[15:0]  = op_wdata[15:0];
      end
      default: merged = op_wdata;
    endcase
    mem_wdata = (state == WR) ? merged : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we     <= 1'b0;
      op_f3     <= 3'b000;
      op_lane   <= 2'b00;
      op_wdata  <= 32'h0;
      buf_word  <= 32'h0;
      mem_addr  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      if (accept) begin
        op_we     <= req_we;
        op_f3     <= req_funct3;
        op_lane   <= req_addr[1:0];
        op_wdata  <= req_wdata;
        mem_addr  <= {req_addr[AW-1:2], 2'b00};
        rsp_err   <= req_err;
        rsp_rdata <= 32'h0;
      end
      if (state == RD) begin
        buf_word <= mem_rdata;
        if (!op_we) rsp_rdata <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Randomized self-checking bench for lsu_rmw with a per-cycle expected-trace model and a 64-word memory.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_rmw #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory seen by the DUT; ref_mem is the model's view of what it must contain
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    if (pre_we)    mem[pre_idx] <= pre_data;
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        rv;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } step_t;

  step_t       exp_q[$];
  step_t       cs;
  int          checks = 0;
  int          errors = 0;
  bit          run = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // cycle-by-cycle comparison against the expected trace; empty trace means idle
  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (exp_q.size() == 0) begin
        chk("idle_ready", 32'(req_ready), 32'h1);
        chk("idle_read", 32'(mem_read), 32'h0);
        chk("idle_write", 32'(mem_write), 32'h0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("idle_wdata", mem_wdata, 32'h0);
        chk("rdata_hold", rsp_rdata, last_rdata);
      end else begin
        cs = exp_q.pop_front();
        chk("busy_ready", 32'(req_ready), 32'h0);
        chk("mem_read", 32'(mem_read), 32'(cs.rd));
        chk("mem_write", 32'(mem_write), 32'(cs.wr));
        chk("rsp_valid", 32'(rsp_valid), 32'(cs.rv));
        chk("mem_wdata", mem_wdata, cs.wr ? cs.wdata : 32'h0);
        if (cs.rd || cs.wr) chk("mem_addr", mem_addr, cs.addr);
        if (cs.rv) begin
          chk("rsp_err", 32'(rsp_err), 32'(cs.err));
          chk("rsp_rdata", rsp_rdata, cs.rdata);
          last_rdata = cs.rdata;
        end
      end
    end
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    ref_mem[idx] = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // called one time unit after a rising edge with the block idle
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold, input bit abort,
                       output logic [31:0] r, output bit e);
    bit          legal, mis;
    logic [31:0] w, nw, wa;
    int unsigned sb, sh;
    step_t       st;
    step_t       tr[$];
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
`endif
    e  = !legal || mis;
    wa = {addr[31:2], 2'b00};
    w  = ref_mem[addr[7:2]];
    nw = w;
    sb = 8 * 32'(addr[1:0]);
    sh = 16 * 32'(addr[1]);
    r  = 32'h0;
    if (e) begin
      st = '0; st.rv = 1'b1; st.err = 1'b1; tr.push_back(st);
    end else if (!we) begin
      st = '0; st.rd = 1'b1; st.addr = wa; tr.push_back(st);
      if (f3[1:0] == 2'd0) begin
        r = (w >> sb) & 32'hFF;
        if (f3 == 3'd0 && r >= 32'h80) r = r | 32'hFFFF_FF00;
      end else if (f3[1:0] == 2'd1) begin
        r = (w >> sh) & 32'hFFFF;
        if (f3 == 3'd1 && r >= 32'h8000) r = r | 32'hFFFF_0000;
      end else begin
        r = w;
      end
      st = '0; st.rv = 1'b1; st.rdata = r; tr.push_back(st);
    end else begin
      if (f3[1:0] == 2'd2) nw = wd;
      else if (f3[1:0] == 2'd0) nw = (w & ~(32'hFF << sb)) | ((wd & 32'hFF) << sb);
      else nw = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      if (f3[1:0] != 2'd2) begin
        st = '0; st.rd = 1'b1; st.addr = wa; tr.push_back(st);
      end
      st = '0; st.wr = 1'b1; st.addr = wa; st.wdata = nw; tr.push_back(st);
      st = '0; st.rv = 1'b1; tr.push_back(st);
    end

    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    foreach (tr[i]) exp_q.push_back(tr[i]);
    if (!hold) req_valid = 1'b0;

    if (abort) begin
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_read_drop", 32'(mem_read), 32'h0);
      chk("abort_ready", 32'(req_ready), 32'h1);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      exp_q.delete();
      last_rdata = 32'h0;
      req_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end else begin
      for (int k = 0; k < tr.size(); k++) begin
        @(posedge clk); #1;
        if (hold) begin
          req_we = 1'($urandom); req_funct3 = 3'($urandom);
          req_addr = $urandom; req_wdata = $urandom;
        end
      end
      req_valid = 1'b0;
      ref_mem[addr[7:2]] = nw;
      chk("trace_drained", 32'(exp_q.size()), 32'h0);
    end
  endtask

  logic [31:0] r;
  bit          e;

  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, r, e);
    chk("sw_err", 32'(e), 32'h0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);

    preload(6'd4, 32'h80FF7F01);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b0, 1'b0, r, e);
    chk("lb_model", r, 32'hFFFFFF80);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 1'b0, r, e);
    chk("lbu_model", r, 32'h00000080);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 1'b0, r, e);
    chk("lh_model", r, 32'hFFFF80FF);
    issue(1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 1'b0, r, e);
    chk("lhu_model", r, 32'h000080FF);

    preload(6'd8, 32'h11223344);
    issue(1'b1, 3'd0, 32'h21, 32'h000000AA, 1'b1, 1'b0, r, e);
    chk("sb_mem", mem[8], 32'h1122AA44);
    issue(1'b1, 3'd1, 32'h22, 32'h00005566, 1'b0, 1'b0, r, e);
    chk("sh_mem", mem[8], 32'h5566AA44);

    preload(6'd1, 32'hCAFEF00D);
    issue(1'b0, 3'd2, 32'h06, 32'h0, 1'b0, 1'b0, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", 32'(e), 32'h1);
    chk("lw_mis_rdata", r, 32'h0);
`else
    chk("lw_mis_err", 32'(e), 32'h0);
    chk("lw_mis_rdata", r, 32'hCAFEF00D);
`endif

    issue(1'b1, 3'd3, 32'h24, 32'h12345678, 1'b1, 1'b0, r, e);
    chk("illegal_store_err", 32'(e), 32'h1);
    chk("illegal_store_mem", mem[9], ref_mem[9]);

    issue(1'b1, 3'd0, 32'h20, 32'h000000EE, 1'b0, 1'b1, r, e);
    chk("abort_mem_unchanged", mem[8], 32'h5566AA44);
    chk("abort_ready_after", 32'(req_ready), 32'h1);

    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)), $urandom,
            ($urandom_range(0, 3) == 0), 1'b0, r, e);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
